// File: rtl/timer_pkg.sv
// timer_pkg: register offsets, field positions, divider limit, APB FSM encoding and byte-strobe merge
package timer_pkg;
  localparam int DIV_MAX_DEF = 8;
  localparam logic [7:0] TCR_OFF   = 8'h00;
  localparam logic [7:0] TDR0_OFF  = 8'h04;
  localparam logic [7:0] TDR1_OFF  = 8'h08;
  localparam logic [7:0] TCMP0_OFF = 8'h0C;
  localparam logic [7:0] TCMP1_OFF = 8'h10;
  localparam logic [7:0] TIER_OFF  = 8'h14;
  localparam logic [7:0] TISR_OFF  = 8'h18;
  localparam logic [7:0] THCSR_OFF = 8'h1C;
  localparam int TEN_BIT  = 0;
  localparam int DEN_BIT  = 1;
  localparam int DIV_LSB  = 8;
  localparam int HREQ_BIT = 0;
  localparam int HACK_BIT = 1;
  typedef enum logic [1:0] {APB_IDLE = 2'd0, APB_SETUP = 2'd1, APB_ACCESS = 2'd2} apb_state_e;
  function automatic logic [31:0] strb_merge(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] strb);
    for (int i = 0; i < 4; i++) strb_merge[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
  endfunction
endpackage

// File: rtl/timer_apb_slave.sv
// timer_apb_slave: APB IDLE/SETUP/ACCESS FSM; pready on the second ACCESS cycle, pslverr qualified by err
import timer_pkg::*;
module timer_apb_slave (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic psel,
  input  logic penable,
  input  logic err,
  output logic pready,
  output logic pslverr
);
  apb_state_e state, state_nx;
  logic waited, waited_nx;
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state  <= APB_IDLE;
      waited <= 1'b0;
    end else begin
      state  <= state_nx;
      waited <= waited_nx;
    end
  always_comb begin
    state_nx  = !psel ? APB_IDLE :
                state == APB_IDLE  ? (penable ? APB_IDLE : APB_SETUP) :
                state == APB_SETUP ? APB_ACCESS :
                waited ? APB_IDLE : APB_ACCESS;
    waited_nx = psel & (state == APB_ACCESS) & ~waited;
    pready    = psel & (state == APB_ACCESS) & waited;
    pslverr   = pready & err;
  end
endmodule

// File: rtl/timer_reg_ctrl.sv
// timer_reg_ctrl: APB register file for the timer (control, count access, compare, interrupt, halt handshake)
import timer_pkg::*;
module timer_reg_ctrl #(
  parameter int DIV_MAX = DIV_MAX_DEF,
  parameter int ADDR_W  = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              tim_psel,
  input  logic              tim_penable,
  input  logic              tim_pwrite,
  input  logic [ADDR_W-1:0] tim_paddr,
  input  logic [31:0]       tim_pwdata,
  input  logic [3:0]        tim_pstrb,
  output logic [31:0]       tim_prdata,
  output logic              tim_pready,
  output logic              tim_pslverr,
  output logic              timer_en,
  output logic              div_en,
  output logic              halt_req,
  output logic [3:0]        div_val,
  input  logic              halt_ack_status,
  input  logic [63:0]       cnt_val,
  output logic              cnt_wr_lo,
  output logic              cnt_wr_hi,
  output logic [31:0]       cnt_wdata,
  output logic              tim_int
);
  logic [31:0] tcmp0, tcmp1, rdata, wm;
  logic int_en, int_st, err, we, clr, match;
  logic a_tcr, a_tdr0, a_tdr1, a_tcmp0, a_tcmp1, a_tier, a_tisr, a_thcsr;
  timer_apb_slave u_apb (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .psel    (tim_psel),
    .penable (tim_penable),
    .err     (err),
    .pready  (tim_pready),
    .pslverr (tim_pslverr)
  );
  always_comb begin
    a_tcr   = tim_paddr == ADDR_W'(TCR_OFF);
    a_tdr0  = tim_paddr == ADDR_W'(TDR0_OFF);
    a_tdr1  = tim_paddr == ADDR_W'(TDR1_OFF);
    a_tcmp0 = tim_paddr == ADDR_W'(TCMP0_OFF);
    a_tcmp1 = tim_paddr == ADDR_W'(TCMP1_OFF);
    a_tier  = tim_paddr == ADDR_W'(TIER_OFF);
    a_tisr  = tim_paddr == ADDR_W'(TISR_OFF);
    a_thcsr = tim_paddr == ADDR_W'(THCSR_OFF);
    rdata = a_tcr   ? (32'(div_val) << DIV_LSB) | (32'(div_en) << DEN_BIT) | (32'(timer_en) << TEN_BIT) :
            a_tdr0  ? cnt_val[31:0] :
            a_tdr1  ? cnt_val[63:32] :
            a_tcmp0 ? tcmp0 :
            a_tcmp1 ? tcmp1 :
            a_tier  ? 32'(int_en) :
            a_tisr  ? 32'(int_st) :
            a_thcsr ? (32'(halt_ack_status) << HACK_BIT) | (32'(halt_req) << HREQ_BIT) : 32'h0;
    wm = strb_merge(rdata, tim_pwdata, tim_pstrb);
    // Divider settings may only change while the timer is stopped or in the same write that stops it
    err = tim_pwrite & a_tcr & ((int'(wm[DIV_LSB +: 4]) > DIV_MAX) |
          (timer_en & wm[TEN_BIT] & ((wm[DEN_BIT] != div_en) | (wm[DIV_LSB +: 4] != div_val))));
    we = tim_pready & tim_pwrite & ~err;
    tim_prdata = tim_pready ? rdata : 32'h0;
    cnt_wr_lo = we & a_tdr0;
    cnt_wr_hi = we & a_tdr1;
    cnt_wdata = wm;
    clr = we & a_tisr & tim_pstrb[0] & tim_pwdata[0];
    match = cnt_val == {tcmp1, tcmp0};
    tim_int = int_st & int_en;
  end
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      timer_en <= 1'b0;
      div_en   <= 1'b0;
      div_val  <= 4'h0;
      tcmp0    <= '1;
      tcmp1    <= '1;
      int_en   <= 1'b0;
      int_st   <= 1'b0;
      halt_req <= 1'b0;
    end else begin
      if (we & a_tcr) begin
        timer_en <= wm[TEN_BIT];
        div_en   <= wm[DEN_BIT];
        div_val  <= wm[DIV_LSB +: 4];
      end
      if (we & a_tcmp0) tcmp0 <= wm;
      if (we & a_tcmp1) tcmp1 <= wm;
      if (we & a_tier) int_en <= wm[0];
      if (we & a_thcsr) halt_req <= wm[HREQ_BIT];
      int_st <= match | (int_st & ~clr);
    end
endmodule
